// File: rtl/display_pkg.sv
// Shared constants, FSM state type and sizing helper for the 7-segment display converter.
// Segment bit order is gfedcba, active-high.
package display_pkg;

    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    // Each BCD digit absorbs a bit more than three binary bits, so ceil(w/3) digits always suffice.
    function automatic int bcd_digits(input int in_w);
        return (in_w + 2) / 3;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment glyph. Codes above 9 and an asserted blank both
// produce an unlit digit.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_GLYPH[digit];
        end
    end

endmodule

// File: rtl/bin_to_7seg_display.sv
// Sequential double-dabble binary to N_DIGITS 7-segment converter, one input bit per cycle.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
//
// Handshake: start is accepted on a rising edge only while busy=0 (FSM in IDLE); value_in is
// sampled on that edge. busy stays high until the ENCODE edge, where seg/overflow are loaded and
// done pulses for exactly one cycle. start during that done cycle is accepted.
module bin_to_7seg_display
    import display_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int N_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       value_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7*N_DIGITS-1:0] seg,
    output logic                  overflow
);

    localparam int BCD_D = bcd_digits(IN_W);
    localparam int PAD_D = (N_DIGITS > BCD_D) ? N_DIGITS : BCD_D;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IN_W-1:0]         bin;
    logic [4*BCD_D-1:0]      bcd;
    logic [4*BCD_D-1:0]      bcd_adj;
    logic [CNT_W-1:0]        cnt;
    logic [4*PAD_D-1:0]      bcd_pad;
    logic [N_DIGITS-1:0]     blank;
    logic                    ovf_nxt;
    logic [7*N_DIGITS-1:0]   seg_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = ENCODE;
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied before each shift so a digit >= 5 carries into the next digit.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_D; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin  <= value_in;
                        bcd  <= '0;
                        cnt  <= CNT_W'(IN_W);
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt - CNT_W'(1);
                end
                ENCODE: begin
                    seg      <= seg_nxt;
                    overflow <= ovf_nxt;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Padding lets N_DIGITS exceed the BCD register; the extra digits read as zero.
    assign bcd_pad = (4*PAD_D)'(bcd);

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
`endif

    always_comb begin
        ovf_nxt = 1'b0;
        for (int k = N_DIGITS; k < PAD_D; k++) begin
            ovf_nxt = ovf_nxt | (bcd_pad[4*k +: 4] != 4'd0);
        end
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            lead     = lead & (bcd_pad[4*k +: 4] == 4'd0);
            blank[k] = lead;
        end
`endif
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic [6:0] glyph;

        seg7_encode u_enc (
            .digit (bcd_pad[4*k +: 4]),
            .blank (blank[k]),
            .seg   (glyph)
        );

        assign seg_nxt[7*k +: 7] = ovf_nxt ? SEG_DASH : glyph;
    end

endmodule
